ir_gree_rx: RTL and testbench

IR_GREE_RX -- requirements
Module: ir_gree_rx

---
 rtl/ir_gree_pkg.sv | 40 ++++
 rtl/ir_pulse_timer.sv | 58 +++++
 rtl/ir_gree_rx.sv | 169 ++++++++++++++++
 tb/tb_ir_gree_rx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ir_gree_pkg.sv
// Shared definitions for the Gree-style IR frame receiver:
// FSM states, pulse windows in microseconds, block sizes and widths.
package ir_gree_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        B35_MARK,
        B35_SPACE,
        CONN_MARK,
        CONN_SPACE,
        B32_MARK,
        B32_SPACE,
        STOP_MARK
    } state_t;

    localparam int LEAD_MARK_MIN_US  = 8000;
    localparam int LEAD_MARK_MAX_US  = 10000;
    localparam int LEAD_SPACE_MIN_US = 4000;
    localparam int LEAD_SPACE_MAX_US = 5000;
    localparam int MARK_MIN_US       = 300;
    localparam int MARK_MAX_US       = 900;
    localparam int ZERO_MIN_US       = 300;
    localparam int ZERO_MAX_US       = 900;
    localparam int ONE_MIN_US        = 1300;
    localparam int ONE_MAX_US        = 2000;
    localparam int CONN_MIN_US       = 18000;
    localparam int CONN_MAX_US       = 22000;

    localparam int B35_LEN = 35;
    localparam int B32_LEN = 32;
    localparam int DUR_W   = 12;
    localparam int BIT_W   = 6;

    function automatic logic [DUR_W-1:0] us2tick(input int us, input int tick_us);
        return DUR_W'(us / tick_us);
    endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Synchronises the IR line, flags its edges and measures how long
// the current level has lasted in saturating ticks.
module ir_pulse_timer
    import ir_gree_pkg::*;
#(
    parameter int PRESCALE = 500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ir_in,
    output logic             rise,
    output logic             fall,
    output logic             level,
    output logic [DUR_W-1:0] dur
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic          s1;
    logic          s2;
    logic          s2_d;
    logic [PW-1:0] pre;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            s2_d <= 1'b1;
        end else begin
            s1   <= ir_in;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign rise  = s2 & ~s2_d;
    assign fall  = ~s2 & s2_d;
    assign level = s2;

    // Every edge restarts the measurement of the new level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            dur <= '0;
        end else if (rise || fall) begin
            pre <= '0;
            dur <= '0;
        end else if (pre == PRE_MAX) begin
            pre <= '0;
            if (dur != '1)
                dur <= dur + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

endmodule

// File: rtl/ir_gree_rx.sv
// Gree IR frame receiver: leader, 35-bit block, connector,
// 32-bit block and stop mark, decoded from pulse-distance timing.
module ir_gree_rx
    import ir_gree_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_US = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir_in,
    output logic [34:0] data35_out,
    output logic [31:0] data32_out,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int PRESCALE = (CLK_HZ / 1000 * TICK_US) / 1000;

    localparam logic [DUR_W-1:0] LM_LO = us2tick(LEAD_MARK_MIN_US, TICK_US);
    localparam logic [DUR_W-1:0] LM_HI = us2tick(LEAD_MARK_MAX_US, TICK_US);
    localparam logic [DUR_W-1:0] LS_LO = us2tick(LEAD_SPACE_MIN_US, TICK_US);
    localparam logic [DUR_W-1:0] LS_HI = us2tick(LEAD_SPACE_MAX_US, TICK_US);
    localparam logic [DUR_W-1:0] MK_LO = us2tick(MARK_MIN_US, TICK_US);
    localparam logic [DUR_W-1:0] MK_HI = us2tick(MARK_MAX_US, TICK_US);
    localparam logic [DUR_W-1:0] Z_LO  = us2tick(ZERO_MIN_US, TICK_US);
    localparam logic [DUR_W-1:0] Z_HI  = us2tick(ZERO_MAX_US, TICK_US);
    localparam logic [DUR_W-1:0] O_LO  = us2tick(ONE_MIN_US, TICK_US);
    localparam logic [DUR_W-1:0] O_HI  = us2tick(ONE_MAX_US, TICK_US);
    localparam logic [DUR_W-1:0] C_LO  = us2tick(CONN_MIN_US, TICK_US);
    localparam logic [DUR_W-1:0] C_HI  = us2tick(CONN_MAX_US, TICK_US);

    localparam logic [BIT_W-1:0] B35_LAST = BIT_W'(B35_LEN - 1);
    localparam logic [BIT_W-1:0] B32_LAST = BIT_W'(B32_LEN - 1);

    logic             rise;
    logic             fall;
    logic             level;
    logic [DUR_W-1:0] dur;

    ir_pulse_timer #(
        .PRESCALE(PRESCALE)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .ir_in(ir_in),
        .rise (rise),
        .fall (fall),
        .level(level),
        .dur  (dur)
    );

    state_t           state;
    logic [BIT_W-1:0] bit_cnt;
    logic [34:0]      sh35;
    logic [31:0]      sh32;

    logic             mark_st;
    logic             bit_sp;
    logic [DUR_W-1:0] lo;
    logic [DUR_W-1:0] hi;
    logic [DUR_W-1:0] lim;
    logic             lvl_end;
    logic             one_ok;
    logic             in_win;
    logic             tmo;
    logic             bit_val;

    // Acceptance window of the level currently being timed.
    always_comb begin
        mark_st = 1'b0;
        bit_sp  = 1'b0;
        lo      = MK_LO;
        hi      = MK_HI;
        unique case (state)
            LEAD_MARK: begin
                mark_st = 1'b1;
                lo      = LM_LO;
                hi      = LM_HI;
            end
            LEAD_SPACE: begin
                lo = LS_LO;
                hi = LS_HI;
            end
            B35_MARK, CONN_MARK, B32_MARK, STOP_MARK: begin
                mark_st = 1'b1;
            end
            B35_SPACE, B32_SPACE: begin
                bit_sp = 1'b1;
                lo     = Z_LO;
                hi     = Z_HI;
            end
            CONN_SPACE: begin
                lo = C_LO;
                hi = C_HI;
            end
            default: ;
        endcase
    end

    assign lim     = bit_sp ? O_HI : hi;
    assign lvl_end = (rise | fall) & (level == mark_st);
    assign one_ok  = bit_sp && (dur >= O_LO) && (dur <= O_HI);
    assign in_win  = ((dur >= lo) && (dur <= hi)) || one_ok;
    assign tmo     = dur > lim;
    assign bit_val = dur >= O_LO;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            sh35        <= '0;
            sh32        <= '0;
            data35_out  <= '0;
            data32_out  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (state == IDLE) begin
                if (fall) begin
                    state <= LEAD_MARK;
                    busy  <= 1'b1;
                end
            end else if ((lvl_end && !in_win) || (!lvl_end && tmo)) begin
                state     <= IDLE;
                busy      <= 1'b0;
                frame_err <= 1'b1;
            end else if (lvl_end) begin
                unique case (state)
                    LEAD_MARK: state <= LEAD_SPACE;
                    LEAD_SPACE: begin
                        state   <= B35_MARK;
                        bit_cnt <= '0;
                    end
                    B35_MARK: state <= B35_SPACE;
                    B35_SPACE: begin
                        sh35[bit_cnt] <= bit_val;
                        bit_cnt       <= bit_cnt + 1'b1;
                        state <= (bit_cnt == B35_LAST) ? CONN_MARK : B35_MARK;
                    end
                    CONN_MARK: state <= CONN_SPACE;
                    CONN_SPACE: begin
                        state   <= B32_MARK;
                        bit_cnt <= '0;
                    end
                    B32_MARK: state <= B32_SPACE;
                    B32_SPACE: begin
                        sh32[bit_cnt[4:0]] <= bit_val;
                        bit_cnt            <= bit_cnt + 1'b1;
                        state <= (bit_cnt == B32_LAST) ? STOP_MARK : B32_MARK;
                    end
                    STOP_MARK: begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        frame_valid <= 1'b1;
                        data35_out  <= sh35;
                        data32_out  <= sh32;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ir_gree_rx.sv
// Bench for ir_gree_rx: frame vectors with faults, a payload model
// and timing checks on frame_valid latency and mark timeout.
`timescale 1us/1ns
module tb_ir_gree_rx;

    // 50 kHz clock with 20 us ticks: one tick per clock.
    localparam int TUS = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        ir_in;
    logic [34:0] data35_out;
    logic [31:0] data32_out;
    logic        frame_valid;
    logic        frame_err;
    logic        busy;

    ir_gree_rx #(
        .CLK_HZ (50_000),
        .TICK_US(TUS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ir_in      (ir_in),
        .data35_out (data35_out),
        .data32_out (data32_out),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [34:0] d35;
        logic [31:0] d32;
        int          fault;
        int          fpos;
        int          gap_us;
        int          exp_v;
        int          exp_e;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    int checks = 0;
    int errors = 0;
    int nv = 0;
    int ne = 0;
    int nboth = 0;

    logic [34:0] m35;
    logic [31:0] m32;

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid) nv++;
            if (frame_err) ne++;
            if (frame_valid && frame_err) nboth++;
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [34:0] d35, input logic [31:0] d32,
                                input int fault, input int fpos, input int gap);
        vec_t v;
        v.d35    = d35;
        v.d32    = d32;
        v.fault  = fault;
        v.fpos   = fpos;
        v.gap_us = gap;
        v.exp_v  = (fault == 0) ? 1 : 0;
        v.exp_e  = (fault == 0 || fault == 4) ? 0 : 1;
        return v;
    endfunction

    task automatic hold(input logic v, input int us);
        ir_in = v;
        repeat (us / TUS) @(negedge clk);
    endtask

    // Mark held low: error must follow the 900 us bound by at most a
    // tick plus synchroniser and register latency.
    task automatic stuck_low();
        int k;
        logic got;
        k   = 0;
        got = 1'b0;
        ir_in = 1'b0;
        while (k < 100 && !got) begin
            @(negedge clk);
            k++;
            if (frame_err) got = 1'b1;
        end
        check("timeout_seen", got, 1);
        checks++;
        if (!(k * TUS > 900 && k * TUS <= 1040)) begin
            errors++;
            $display("FAIL timeout_delay: got %0d us expected 920..1040 us", k * TUS);
        end
    endtask

    task automatic send(input vec_t v);
        logic [3:0] fv;
        hold(1'b0, (v.fault == 1) ? 7000 : 9000);
        if (v.fault == 1) return;
        hold(1'b1, 4500);
        check("busy_in_frame", busy, 1);
        for (int i = 0; i < 35; i++) begin
            if (v.fault == 2 && i == v.fpos) begin
                stuck_low();
                return;
            end
            hold(1'b0, 560);
            hold(1'b1, v.d35[i] ? 1690 : 560);
        end
        hold(1'b0, 560);
        hold(1'b1, 20000);
        for (int i = 0; i < 32; i++) begin
            hold(1'b0, 560);
            if (v.fault == 3 && i == v.fpos) begin
                hold(1'b1, 1100);
                hold(1'b0, 560);
                return;
            end
            if (v.fault == 4 && i == v.fpos) begin
                ir_in = 1'b1;
                repeat (5) @(negedge clk);
                rst = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                return;
            end
            hold(1'b1, v.d32[i] ? 1690 : 560);
        end
        hold(1'b0, 560);
        ir_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            fv[k] = frame_valid;
        end
        check("valid_latency", {60'd0, fv}, 64'b0100);
        @(negedge clk);
    endtask

    initial begin
        int v0;
        int e0;
        int f8;

        f8 = ($urandom_range(0, 1) == 1) ? 0 : 3;
        vecs[0] = mk(35'b11111000001111100000111110000011111,
                     32'b11111000001111100000111110000011, 0, 0, 5000);
        vecs[1] = mk(35'h7_1234_5678, 32'hdead_beef, 1, 0, 5000);
        vecs[2] = mk(35'h5_5555_5555, 32'h5555_5555, 2, 20, 5000);
        vecs[3] = mk(35'({$urandom, $urandom}), $urandom, 0, 0, 5000);
        vecs[4] = mk(35'h0_ffff_0000, 32'h00ff_00ff, 3, 10, 5000);
        vecs[5] = mk(35'h1_0000_0001, 32'h8000_0001, 4, 12, 5000);
        vecs[6] = mk(35'd0, 32'd0, 0, 0, 40000);
        vecs[7] = mk(35'({$urandom, $urandom}), $urandom, 0, 0, 5000);
        vecs[8] = mk(35'({$urandom, $urandom}), $urandom, f8,
                     $urandom_range(0, 31), 5000);

        m35   = '0;
        m32   = '0;
        rst   = 1'b1;
        ir_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data35", data35_out, 0);
        check("rst_data32", data32_out, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {frame_valid, frame_err}, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            v0 = nv;
            e0 = ne;
            send(vecs[i]);
            hold(1'b1, vecs[i].gap_us);
            if (vecs[i].fault == 0) begin
                m35 = vecs[i].d35;
                m32 = vecs[i].d32;
            end else if (vecs[i].fault == 4) begin
                m35 = '0;
                m32 = '0;
            end
            check($sformatf("v%0d_valid_cnt", i), nv - v0, vecs[i].exp_v);
            check($sformatf("v%0d_err_cnt", i), ne - e0, vecs[i].exp_e);
            check($sformatf("v%0d_data35", i), data35_out, m35);
            check($sformatf("v%0d_data32", i), data32_out, m32);
            check($sformatf("v%0d_busy", i), busy, 0);
        end

        check("valid_err_exclusive", nboth, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
